// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
// Raster timing generator for a parallel RGB LCD panel. A horizontal and a
// vertical counter sweep the full frame (sync, back porch, active area and
// front porch). Every output is a purely combinational decode of those two
// registered counters and lcd_en, so none of them adds a clock of latency.
//
// Ports
//   clk         in   pixel clock
//   rstn        in   asynchronous active-low reset (clears both counters)
//   lcd_en      in   timing enable; low clears and holds both counters
//   lcd_hs      out  horizontal sync, active low
//   lcd_vs      out  vertical sync, active low
//   lcd_de      out  data enable, active high
//   data_req    out  pixel request, one clock ahead of lcd_de
//   pixel_xpos  out  column of the requested pixel (0 when data_req=0)
//   pixel_ypos  out  row of the requested pixel (0 when data_req=0)
//   frame_start out  single-clock pulse at the frame origin
module lcd_timing_gen #(
  parameter int H_SYNC  = 128,
  parameter int H_BACK  = 88,
  parameter int H_DISP  = 800,
  parameter int H_TOTAL = 1056,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_DISP  = 480,
  parameter int V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        lcd_en,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic        data_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        frame_start
);

  // Window edges, pre-cast to the 11-bit counter width.
  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_END    = 11'(H_SYNC);
  localparam logic [10:0] VS_END    = 11'(V_SYNC);
  localparam logic [10:0] HA_LO     = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] HA_HI     = 11'(H_SYNC + H_BACK + H_DISP);
  // The request window is the active window moved one clock earlier, which
  // gives the downstream pixel source a clock to produce its data.
  localparam logic [10:0] REQ_LO    = 11'(H_SYNC + H_BACK - 1);
  localparam logic [10:0] REQ_HI    = 11'(H_SYNC + H_BACK + H_DISP - 1);
  localparam logic [10:0] VA_LO     = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] VA_HI     = 11'(V_SYNC + V_BACK + V_DISP);

  logic [10:0] h_cnt_q, h_cnt_d;
  logic [10:0] v_cnt_q, v_cnt_d;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (!lcd_en) begin
      // Dropping the enable aborts the frame; the next enable restarts at
      // the origin.
      h_cnt_d = '0;
      v_cnt_d = '0;
    end else if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 11'd0 : v_cnt_q + 11'd1;
    end else begin
      h_cnt_d = h_cnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  logic h_active;
  logic v_active;
  logic h_request;

  assign h_active  = (h_cnt_q >= HA_LO)  && (h_cnt_q < HA_HI);
  assign v_active  = (v_cnt_q >= VA_LO)  && (v_cnt_q < VA_HI);
  assign h_request = (h_cnt_q >= REQ_LO) && (h_cnt_q < REQ_HI);

  assign lcd_hs      = ~(lcd_en && (h_cnt_q < HS_END));
  assign lcd_vs      = ~(lcd_en && (v_cnt_q < VS_END));
  assign lcd_de      = lcd_en && h_active && v_active;
  assign data_req    = lcd_en && h_request && v_active;
  assign frame_start = lcd_en && (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);

  // The subtractions cannot underflow: they are only selected inside the
  // request window, where both counters are at or above the subtrahend.
  assign pixel_xpos = data_req ? (h_cnt_q - REQ_LO) : 11'd0;
  assign pixel_ypos = data_req ? (v_cnt_q - VA_LO)  : 11'd0;

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_SYNC, 128, hsync width in clocks
- H_BACK, 88, horizontal back porch
- H_DISP, 800, active pixels per line
- H_TOTAL, 1056, clocks per line
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch
- V_DISP, 480, active lines
- V_TOTAL, 525, lines per frame
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, pixel clock
- rstn, in, 1, reset
- lcd_en, in, 1, timing enable
- lcd_hs, out, 1, hsync, active low
- lcd_vs, out, 1, vsync, active low
- lcd_de, out, 1, data enable, active high
- data_req, out, 1, pixel request, one clock ahead of lcd_de
- pixel_xpos, out, 11, column of the pixel requested by data_req
- pixel_ypos, out, 11, row of the pixel requested by data_req
- frame_start, out, 1, one-clock pulse at frame origin
REQ-003 The block SHALL use one clock, clk; reset rstn SHALL be asynchronous and active-low.

Function
REQ-004 h_cnt (11 bit) SHALL count 0..H_TOTAL-1 each clk while lcd_en=1, wrapping to 0.
REQ-005 v_cnt (11 bit) SHALL increment only on the clock where h_cnt wraps, counting 0..V_TOTAL-1 and wrapping to 0.
REQ-006 While lcd_en=0, both counters SHALL be cleared to 0 at the next clk edge and held there.
REQ-007 Deasserting lcd_en mid-frame SHALL abort the frame; reasserting it SHALL restart at h_cnt=0, v_cnt=0.
REQ-008 Outputs SHALL be combinational decodes of the registered counters and lcd_en; there SHALL be no added latency.
REQ-009 lcd_hs SHALL be 0 when lcd_en=1 and h_cnt<H_SYNC, otherwise 1.
REQ-010 lcd_vs SHALL be 0 when lcd_en=1 and v_cnt<V_SYNC, otherwise 1.
REQ-011 Horizontal active (HA) SHALL be H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_DISP.
REQ-012 Vertical active (VA) SHALL be V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_DISP.
REQ-013 lcd_de SHALL be 1 iff lcd_en=1, HA holds and VA holds.
REQ-014 data_req SHALL be 1 iff lcd_en=1, VA holds and H_SYNC+H_BACK-1 <= h_cnt < H_SYNC+H_BACK+H_DISP-1, so that it leads lcd_de by exactly one clock.
REQ-015 pixel_xpos SHALL equal h_cnt-(H_SYNC+H_BACK-1) when data_req=1, otherwise 0.
REQ-016 pixel_ypos SHALL equal v_cnt-(V_SYNC+V_BACK) when data_req=1, otherwise 0.
REQ-017 The one-clock lead of pixel_xpos/pixel_ypos SHALL absorb the one-register latency of the downstream area decoder and pixel source.
REQ-018 frame_start SHALL be 1 for exactly one clock, when lcd_en=1, h_cnt=0 and v_cnt=0.
REQ-019 Subtractions SHALL be 11-bit unsigned and SHALL never underflow within the gated ranges above.

Reset
REQ-020 On rstn=0, h_cnt and v_cnt SHALL clear to 0 immediately, independent of clk.
REQ-021 During reset, outputs SHALL decode from zero counters: with lcd_en=1, lcd_hs=0, lcd_vs=0, lcd_de=0, data_req=0, pixel_xpos=0, pixel_ypos=0, frame_start=1.
REQ-022 During reset with lcd_en=0, lcd_hs=1, lcd_vs=1 and all other outputs SHALL be 0.
REQ-023 After rstn rises with lcd_en=1, counting SHALL begin on the first clk edge.

Verification
REQ-024 Scenario: lcd_en=1, v_cnt=35 -> data_req rises at h_cnt=215 with pixel_xpos=0; lcd_de rises at h_cnt=216.
REQ-025 Scenario: lcd_en=1, v_cnt=35 -> at h_cnt=1014, pixel_xpos=799; at h_cnt=1015, data_req=0 and lcd_de=1; at h_cnt=1016, lcd_de=0.
REQ-026 Scenario: lcd_en=1 -> lcd_hs is low for 128 clocks per 1056; lcd_vs is low for 2112 clocks; frame_start pulses every 554400 clocks.
REQ-027 Scenario: lcd_en=1 -> pixel_ypos=0 on line 35 and 479 on line 514; lines 0-34 and 515-524 have no data_req.
REQ-028 Scenario: lcd_en dropped at v_cnt=200, h_cnt=500 -> counters are 0 next clock, lcd_hs=lcd_vs=1, lcd_de=0; on re-enable, frame_start pulses.
REQ-029 Scenario: rstn asserted asynchronously mid-line -> counters reach 0 before the next clk edge, and outputs match REQ-021.
